// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates VGA raster timing from a pixel-advance strobe. Two counters
//   (h_cnt, v_cnt) walk the full raster including blanking. All outputs are
//   registered and decoded from the next-state counter values, so they change
//   on the same clock edge as the position.
//
// Ports:
//   clk_i          system clock
//   arstn_i        asynchronous active-low reset
//   pix_strb_i     pixel-advance strobe (one advance per clk while high)
//   hsync_o        horizontal sync, level HSYNC_ACTIVE inside the sync region
//   vsync_o        vertical sync, level VSYNC_ACTIVE inside the sync region
//   de_o           display enable, high in the visible region
//   x_o            current horizontal position (0 .. H_TOTAL-1)
//   y_o            current vertical position   (0 .. V_TOTAL-1)
//   line_start_o   one-clk pulse after the position enters x = 0
//   frame_start_o  one-clk pulse after the position enters (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter logic        HSYNC_ACTIVE = 1'b0,
  parameter logic        VSYNC_ACTIVE = 1'b0,
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned XW      = $clog2(H_TOTAL),
  localparam int unsigned YW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          pix_strb_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  // A zero-length region would collapse the raster and break the decode.
  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_param
    $error("vga_timing_gen: timing parameters must all be non-zero");
  end

  // Region boundaries, cast to counter width. All are below the totals
  // because every back porch is at least one, so the casts never truncate.
  localparam logic [XW-1:0] H_LAST      = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_VIS_END   = XW'(H_VISIBLE);
  localparam logic [XW-1:0] H_SYNC_BEG  = XW'(H_VISIBLE + H_FRONT);
  localparam logic [XW-1:0] H_SYNC_END  = XW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] V_LAST      = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS_END   = YW'(V_VISIBLE);
  localparam logic [YW-1:0] V_SYNC_BEG  = YW'(V_VISIBLE + V_FRONT);
  localparam logic [YW-1:0] V_SYNC_END  = YW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic [XW-1:0] h_nxt;
  logic [YW-1:0] v_nxt;
  logic          de_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          line_nxt;
  logic          frame_nxt;

  // Next raster position. Wrap is by explicit compare so non-power-of-two
  // totals work without relying on counter overflow.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_strb_i) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        if (v_cnt == V_LAST) begin
          v_nxt = '0;
        end else begin
          v_nxt = v_cnt + YW'(1);
        end
      end else begin
        h_nxt = h_cnt + XW'(1);
      end
    end
  end

  // Decode from the next position so registered outputs line up with the
  // counters. Pulses only fire on an advancing edge; otherwise they clear.
  always_comb begin
    de_nxt    = (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
    hsync_nxt = ((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    vsync_nxt = ((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    line_nxt  = pix_strb_i && (h_nxt == '0);
    frame_nxt = pix_strb_i && (h_nxt == '0) && (v_nxt == '0);
  end

  // Reset parks the raster on the last blanking pixel so the first strobe
  // lands on (0,0) and produces a frame start.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      de_o          <= 1'b0;
      hsync_o       <= ~HSYNC_ACTIVE;
      vsync_o       <= ~VSYNC_ACTIVE;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      de_o          <= de_nxt;
      hsync_o       <= hsync_nxt;
      vsync_o       <= vsync_nxt;
      line_start_o  <= line_nxt;
      frame_start_o <= frame_nxt;
    end
  end

  assign x_o = h_cnt;
  assign y_o = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen with a small raster: H = 4/1/2/1
// (8 pixels per line), V = 3/1/1/1 (6 lines per frame), active-low syncs.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int H_TOTAL = 8;
  localparam int V_TOTAL = 6;

  logic       clk = 1'b0;
  logic       arstn = 1'b1;
  logic       pixStrb = 1'b0;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [2:0] x;
  logic [2:0] y;
  logic       lineStart;
  logic       frameStart;

  int assertCount = 0;
  int failCount = 0;
  int ex = 7;
  int ey = 5;
  int fsSeen;
  int vsLow;
  int deHigh;

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0)
  ) dut (
    .clk_i(clk),
    .arstn_i(arstn),
    .pix_strb_i(pixStrb),
    .hsync_o(hsync),
    .vsync_o(vsync),
    .de_o(de),
    .x_o(x),
    .y_o(y),
    .line_start_o(lineStart),
    .frame_start_o(frameStart)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Drive the strobe level and let n falling edges pass.
  task automatic applyStimulus(input logic strb, input int n);
    pixStrb = strb;
    repeat (n) @(negedge clk);
  endtask

  // Single compared value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Full output set against explicit values.
  task automatic checkAll(input string tag, input int xe, input int ye, input logic dee,
                          input logic hse, input logic vse, input logic lse, input logic fse);
    checkOutput({tag, " x"}, 32'(x), 32'(xe));
    checkOutput({tag, " y"}, 32'(y), 32'(ye));
    checkOutput({tag, " de"}, 32'(de), 32'(dee));
    checkOutput({tag, " hsync"}, 32'(hsync), 32'(hse));
    checkOutput({tag, " vsync"}, 32'(vsync), 32'(vse));
    checkOutput({tag, " line_start"}, 32'(lineStart), 32'(lse));
    checkOutput({tag, " frame_start"}, 32'(frameStart), 32'(fse));
  endtask

  // Reference raster position: advance by one pixel.
  task automatic modelStep();
    if (ex == H_TOTAL - 1) begin
      ex = 0;
      ey = (ey == V_TOTAL - 1) ? 0 : ey + 1;
    end else begin
      ex = ex + 1;
    end
  endtask

  // Full output set against the reference position, with given pulse levels.
  task automatic checkModel(input string tag, input logic lse, input logic fse);
    checkAll(tag, ex, ey, (ex < 4) && (ey < 3), !(ex == 5 || ex == 6), !(ey == 4), lse, fse);
  endtask

  initial begin
    // Reset with no strobes: parked on the last blanking pixel.
    #1 arstn = 1'b0;
    applyStimulus(1'b0, 2);
    checkAll("reset", 7, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    arstn = 1'b1;
    applyStimulus(1'b0, 4);
    checkAll("reset_hold", 7, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // First strobe lands on (0,0) with both pulses; pulses clear without strobe.
    applyStimulus(1'b1, 1);
    checkAll("first_strobe", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1);
    checkAll("pulse_clear", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // One line with a strobe every clk, hand-computed decode.
    applyStimulus(1'b1, 1); checkAll("line x1", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1); checkAll("line x2", 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1); checkAll("line x3", 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1); checkAll("line x4", 4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1); checkAll("line x5", 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1); checkAll("line x6", 6, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1); checkAll("line x7", 7, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1); checkAll("line wrap", 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    ex = 0;
    ey = 1;

    // Two full frames with the strobe held high.
    fsSeen = 0;
    vsLow = 0;
    deHigh = 0;
    for (int i = 0; i < 2 * H_TOTAL * V_TOTAL; i++) begin
      applyStimulus(1'b1, 1);
      modelStep();
      checkModel("frames", ex == 0, (ex == 0) && (ey == 0));
      if (frameStart) fsSeen++;
      if (!vsync) vsLow++;
      if (de) deHigh++;
    end
    checkOutput("frames frame_start count", 32'(fsSeen), 32'd2);
    checkOutput("frames vsync low count", 32'(vsLow), 32'd16);
    checkOutput("frames de high count", 32'(deHigh), 32'd24);

    // Strobe every 4th clk: advance on the strobe edge, hold for three clks.
    for (int i = 0; i < H_TOTAL; i++) begin
      applyStimulus(1'b1, 1);
      modelStep();
      checkModel("div4 strobe", ex == 0, (ex == 0) && (ey == 0));
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b0, 1);
        checkModel("div4 hold", 1'b0, 1'b0);
      end
    end

    // Reset asserted mid-line at (2,1) takes effect without a clock edge.
    arstn = 1'b0;
    applyStimulus(1'b0, 1);
    arstn = 1'b1;
    applyStimulus(1'b1, 11);
    checkAll("pre_reset", 2, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pixStrb = 1'b0;
    #2 arstn = 1'b0;
    #1 checkAll("async_reset", 7, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    arstn = 1'b1;
    applyStimulus(1'b1, 1);
    checkAll("restart", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1);
    checkAll("restart_clear", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
